// File: rtl/pixel_fetch.sv
// rtl/pixel_fetch.sv - frame fetcher streaming image words from memory to the shift data path
// Optional border padding is selected by defining PIXEL_FETCH_ROW_PAD_EN.
module pixel_fetch #(
  parameter int WIDTH_WORDS = 160,
  parameter int HEIGHT_ROWS = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        hold,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        write_en,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef PIXEL_FETCH_ROW_PAD_EN
  localparam logic [2:0] S_PAD   = 3'd3;
`endif

  localparam logic [15:0] LAST_COL = 16'(WIDTH_WORDS - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT_ROWS - 1);

  logic [2:0]  state;
  logic [15:0] col;
  logic [15:0] row;
`ifdef PIXEL_FETCH_ROW_PAD_EN
  // Distinguishes the zero word before a row from the one after it.
  logic        pad_lead;
`endif

  // mem_addr doubles as the address register; it only moves on an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      write_en <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PIXEL_FETCH_ROW_PAD_EN
      pad_lead <= 1'b0;
`endif
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr <= base_addr;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
`ifdef PIXEL_FETCH_ROW_PAD_EN
            state    <= S_PAD;
            pad_lead <= 1'b1;
`else
            state    <= S_REQ;
            mem_req  <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            data_out <= mem_rdata;
            write_en <= 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (col == LAST_COL) begin
              col <= '0;
`ifdef PIXEL_FETCH_ROW_PAD_EN
              mem_req  <= 1'b0;
              pad_lead <= 1'b0;
              state    <= S_PAD;
`else
              if (row == LAST_ROW) begin
                mem_req <= 1'b0;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                row <= row + 16'd1;
                if (hold) begin
                  mem_req <= 1'b0;
                  state   <= S_PAUSE;
                end
              end
`endif
            end else begin
              col <= col + 16'd1;
              if (hold) begin
                mem_req <= 1'b0;
                state   <= S_PAUSE;
              end
            end
          end
        end
        S_PAUSE: begin
          if (!hold) begin
            mem_req <= 1'b1;
            state   <= S_REQ;
          end
        end
`ifdef PIXEL_FETCH_ROW_PAD_EN
        S_PAD: begin
          if (!hold) begin
            write_en <= 1'b1;
            data_out <= '0;
            if (pad_lead) begin
              mem_req <= 1'b1;
              state   <= S_REQ;
            end else if (row == LAST_ROW) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              row      <= row + 16'd1;
              pad_lead <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb/tb_pixel_fetch.sv - randomized bench for pixel_fetch against a frame-level reference model
module tb_pixel_fetch;

  localparam int W = 4;
  localparam int H = 2;
`ifdef PIXEL_FETCH_ROW_PAD_EN
  localparam int PADW = 1;
`else
  localparam int PADW = 0;
`endif
  localparam int ROW_STROBES = W + 2 * PADW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        hold = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        write_en;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  pixel_fetch #(.WIDTH_WORDS(W), .HEIGHT_ROWS(H)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .write_en(write_en), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state: the whole expected frame is laid out up front.
  logic [31:0] data_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] key = '0;
  int ack_pct = 100;
  int hold_pct = 0;
  bit force_ack = 1'b0;
  int cyc = 0, strobes = 0, acks = 0, done_cnt = 0, first_we = -1, last_we = -1;
  bit prev_wait = 1'b0, prev_ack_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  // Memory responder and output monitor; outputs are sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mem_ack = 1'b0;
      hold = 1'b0;
      prev_wait = 1'b0;
      prev_ack_hold = 1'b0;
    end else begin
      if (write_en) begin
        strobes++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        check("strobe_expected", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) check("data_out", data_out, data_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", 32'(busy), 32'd1);
        check("frame_drained", 32'(data_q.size()), 32'd0);
      end
      if (prev_wait) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("addr_stable", mem_addr, prev_addr);
      end
      if (prev_ack_hold) check("pause_req_low", 32'(mem_req), 32'd0);
      hold = ($urandom_range(0, 99) < hold_pct);
      mem_ack = force_ack || (mem_req && ($urandom_range(0, 99) < ack_pct));
      mem_rdata = (mem_ack && mem_req) ? (mem_addr ^ key) : $urandom;
      if (mem_ack && mem_req) begin
        acks++;
        check("req_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("mem_addr", mem_addr, addr_q.pop_front());
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_ack_hold = mem_req && mem_ack && hold;
    end
  end

  task automatic load_frame(input logic [31:0] base, input logic [31:0] k);
    logic [31:0] a;
    key = k;
    data_q.delete();
    addr_q.delete();
    for (int r = 0; r < H; r++) begin
      if (PADW != 0) data_q.push_back(32'd0);
      for (int c = 0; c < W; c++) begin
        a = base + 32'(4 * (r * W + c));
        addr_q.push_back(a);
        data_q.push_back(a ^ k);
      end
      if (PADW != 0) data_q.push_back(32'd0);
    end
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(negedge clk);
    #1 start = 1'b1;
    base_addr = base;
    @(negedge clk);
    #1 start = 1'b0;
    base_addr = $urandom;
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [31:0] k,
                           input int ap, input int hp, input bit poke);
    int d0, s0;
    bit timeout;
    load_frame(base, k);
    ack_pct = ap;
    hold_pct = hp;
    d0 = done_cnt;
    s0 = strobes;
    first_we = -1;
    pulse_start(base);
    timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        timeout = 1'b0;
        break;
      end
      if (poke && i == 3) begin
        #2 start = 1'b1;
        base_addr = $urandom;
        @(posedge clk);
        #2 start = 1'b0;
      end
    end
    check("frame_timeout", 32'(timeout), 32'd0);
    #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_after_done", 32'(done), 32'd0);
    check("strobe_total", 32'(strobes - s0), 32'(ROW_STROBES * H));
    check("addr_drained", 32'(addr_q.size()), 32'd0);
    if (ap == 100 && hp == 0) check("strobe_span", 32'(last_we - first_we), 32'(ROW_STROBES * H - 1));
    hold_pct = 0;
    repeat (4) @(posedge clk);
    check("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_write_en"}, 32'(write_en), 32'd0);
    check({tag, "_data_out"}, data_out, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int a0, d0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(32'h100, 32'h0, 100, 0, 1'b0);
    run_frame(32'h100, 32'h0, 25, 0, 1'b0);
    run_frame(32'h100, 32'h0, 100, 40, 1'b0);
    for (int f = 0; f < 4; f++)
      run_frame($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(30, 100), $urandom_range(0, 50), 1'b1);
    run_frame(32'hFFFF_FFF0, $urandom, 70, 20, 1'b1);

    // Abort mid-frame, then confirm a late ack in IDLE produces nothing.
    load_frame(32'h300, $urandom);
    ack_pct = 60;
    hold_pct = 20;
    a0 = acks;
    d0 = done_cnt;
    pulse_start(32'h300);
    for (int i = 0; i < 500 && (acks - a0) < 5; i++) @(posedge clk);
    check("abort_reached", 32'(acks - a0 >= 5), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outputs_zero("abort");
    data_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    force_ack = 1'b0;
    check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
    check("idle_after_late_ack", 32'(busy), 32'd0);
    run_frame(32'h200, $urandom, 80, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
